// File: rtl/branch_pred_ctrl.sv
// Direct-mapped 2-bit saturating-counter branch predictor with registered
// mispredict/redirect pulse and saturating branch/mispredict statistics.
module branch_pred_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic            resolve_pred,
  input  logic [PC_W-1:0] resolve_target,
  input  logic [PC_W-1:0] resolve_fallthru,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     branch_cnt,
  output logic [15:0]     mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_table [ENTRIES];
  logic [IDX_BITS-1:0] lidx;
  logic [IDX_BITS-1:0] ridx;
  logic                accept;
  logic                wrong;
  logic [1:0]          cur_ctr;
  logic [1:0]          upd_ctr;
  logic                unused_pc_bits;

  assign lidx   = lookup_pc[IDX_BITS:1];
  assign ridx   = resolve_pc[IDX_BITS:1];
  // Resolves seen during a redirect pulse belong to the flushed wrong path.
  assign accept = resolve_valid & ~mispredict;
  assign wrong  = resolve_taken ^ resolve_pred;

  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_BITS+1], lookup_pc[0],
                            resolve_pc[PC_W-1:IDX_BITS+1], resolve_pc[0]};

  always_comb begin
    cur_ctr = ctr_table[ridx];
    upd_ctr = cur_ctr;
    if (resolve_taken) begin
      if (cur_ctr != 2'b11) upd_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) upd_ctr = cur_ctr - 2'b01;
    end
  end

  always_comb begin
    pred_taken = ctr_table[lidx][1];
    if (accept && (ridx == lidx)) pred_taken = upd_ctr[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= 2'b00;
    end else if (accept) begin
      ctr_table[ridx] <= upd_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= accept & wrong;
      if (accept) begin
        redirect_pc <= resolve_taken ? resolve_target : resolve_fallthru;
        if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
        if (wrong && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed self-checking bench for branch_pred_ctrl.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lookup_pc;
  logic        pred_taken;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_pred;
  logic [15:0] resolve_target;
  logic [15:0] resolve_fallthru;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_b = 0;
  int exp_m = 0;

  branch_pred_ctrl #(.IDX_BITS(4), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
    .resolve_target(resolve_target), .resolve_fallthru(resolve_fallthru),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pc, input logic tk, input logic pr,
                       input logic [15:0] tgt, input logic [15:0] ft);
    resolve_valid    = 1'b1;
    resolve_pc       = pc;
    resolve_taken    = tk;
    resolve_pred     = pr;
    resolve_target   = tgt;
    resolve_fallthru = ft;
  endtask

  task automatic peek(input logic [15:0] pc, input string tag, input logic exp);
    lookup_pc = pc;
    #1;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // walk at 0x0010: outcome, prediction fetch used, resulting pred, pulse
  logic walk_tk [7] = '{1, 1, 1, 1, 0, 0, 0};
  logic walk_pr [7] = '{0, 0, 1, 1, 1, 1, 0};
  logic walk_pt [7] = '{0, 1, 1, 1, 1, 0, 0};
  logic walk_mp [7] = '{1, 1, 0, 0, 1, 1, 0};
  // back-to-back chain at 0x0006: outcome and resulting pred
  logic chain_tk [5] = '{1, 1, 1, 0, 0};
  logic chain_pt [5] = '{0, 1, 1, 1, 0};

  initial begin
    rst = 1'b1;
    lookup_pc = '0;
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_taken = 1'b0;
    resolve_pred = 1'b0;
    resolve_target = '0;
    resolve_fallthru = '0;
    tick();
    tick();
    rst = 1'b0;

    peek(16'h0000, "rst_pt_0000", 1'b0);
    peek(16'h001E, "rst_pt_001e", 1'b0);
    peek(16'hFFFE, "rst_pt_fffe", 1'b0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_redirect", {16'd0, redirect_pc}, 32'd0);
    chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);

    // saturation walk with an idle cycle after each so pulses never suppress
    lookup_pc = 16'h0010;
    for (int i = 0; i < 7; i++) begin
      drive(16'h0010, walk_tk[i], walk_pr[i], 16'h0200, 16'h0012);
      tick();
      resolve_valid = 1'b0;
      exp_b++;
      if (walk_mp[i]) exp_m++;
      #1;
      chk($sformatf("walk%0d_pt", i), {31'd0, pred_taken}, {31'd0, walk_pt[i]});
      chk($sformatf("walk%0d_mp", i), {31'd0, mispredict}, {31'd0, walk_mp[i]});
      tick();
    end
    chk("walk_branch_cnt", {16'd0, branch_cnt}, 32'd7);
    chk("walk_mispred_cnt", {16'd0, mispred_cnt}, 32'd4);

    // back-to-back chain; valid dropped briefly mid-cycle to see the raw entry
    lookup_pc = 16'h0006;
    drive(16'h0006, chain_tk[0], chain_tk[0], 16'h0300, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      tick();
      resolve_valid = 1'b0;
      exp_b++;
      #1;
      chk($sformatf("chain%0d_pt", i), {31'd0, pred_taken}, {31'd0, chain_pt[i]});
      chk($sformatf("chain%0d_mp", i), {31'd0, mispredict}, 32'd0);
      if (i < 4) drive(16'h0006, chain_tk[i+1], chain_tk[i+1], 16'h0300, 16'h0008);
    end
    chk("chain_branch_cnt", {16'd0, branch_cnt}, exp_b);

    // mispredict redirect, taken then not-taken
    drive(16'h0040, 1'b1, 1'b0, 16'h0100, 16'h0042);
    tick();
    resolve_valid = 1'b0;
    exp_b++; exp_m++;
    chk("redir_t_mp", {31'd0, mispredict}, 32'd1);
    chk("redir_t_pc", {16'd0, redirect_pc}, 32'h0100);
    chk("redir_t_mcnt", {16'd0, mispred_cnt}, 32'd5);
    tick();
    chk("redir_t_mp_off", {31'd0, mispredict}, 32'd0);
    chk("redir_t_pc_hold", {16'd0, redirect_pc}, 32'h0100);
    drive(16'h0040, 1'b0, 1'b1, 16'h0100, 16'h0042);
    tick();
    resolve_valid = 1'b0;
    exp_b++; exp_m++;
    chk("redir_nt_mp", {31'd0, mispredict}, 32'd1);
    chk("redir_nt_pc", {16'd0, redirect_pc}, 32'h0042);
    chk("redir_nt_mcnt", {16'd0, mispred_cnt}, 32'd6);
    tick();
    chk("redir_nt_mp_off", {31'd0, mispredict}, 32'd0);

    // wrong-path resolve during the pulse
    drive(16'h0002, 1'b1, 1'b0, 16'h0400, 16'h0004);
    tick();
    exp_b++; exp_m++;
    chk("wp_first_mp", {31'd0, mispredict}, 32'd1);
    drive(16'h0002, 1'b1, 1'b0, 16'h0500, 16'h0004);
    peek(16'h0002, "wp_no_bypass", 1'b0);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("wp_no_pulse", {31'd0, mispredict}, 32'd0);
    chk("wp_branch_cnt", {16'd0, branch_cnt}, exp_b);
    chk("wp_mispred_cnt", {16'd0, mispred_cnt}, exp_m);
    chk("wp_redirect", {16'd0, redirect_pc}, 32'h0400);
    chk("wp_table", {31'd0, pred_taken}, 32'd0);

    // bypass and aliasing at index 4
    drive(16'h0008, 1'b1, 1'b0, 16'h0600, 16'h000A);
    tick();
    resolve_valid = 1'b0;
    exp_b++; exp_m++;
    tick();
    peek(16'h0008, "byp_before", 1'b0);
    drive(16'h0008, 1'b1, 1'b0, 16'h0600, 16'h000A);
    #1;
    chk("byp_same_cycle", {31'd0, pred_taken}, 32'd1);
    tick();
    resolve_valid = 1'b0;
    exp_b++; exp_m++;
    peek(16'h0028, "alias_0028", 1'b1);
    tick();

    // branch_cnt saturation with back-to-back correct predictions
    drive(16'h0030, 1'b0, 1'b0, 16'h0700, 16'h0032);
    for (int i = 0; i < 65535; i++) tick();
    resolve_valid = 1'b0;
    #1;
    chk("sat_branch_cnt", {16'd0, branch_cnt}, 32'hFFFF);
    chk("sat_mispred_cnt", {16'd0, mispred_cnt}, exp_m);
    drive(16'h0030, 1'b0, 1'b0, 16'h0700, 16'h0032);
    tick();
    resolve_valid = 1'b0;
    chk("sat_hold", {16'd0, branch_cnt}, 32'hFFFF);

    // reset wins over a simultaneous mispredicting resolve
    drive(16'h0008, 1'b1, 1'b0, 16'h0800, 16'h000A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resolve_valid = 1'b0;
    #1;
    chk("rr_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rr_redirect", {16'd0, redirect_pc}, 32'd0);
    chk("rr_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rr_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    peek(16'h0008, "rr_pt_0008", 1'b0);
    peek(16'h0006, "rr_pt_0006", 1'b0);
    tick();
    chk("rr_no_late_pulse", {31'd0, mispredict}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
